// File: rtl/gpio_ext_pkg.sv
// GPIO_EXT shared definitions.
// Register offsets (paddr[5:2]) and interrupt type encoding.
package gpio_ext_pkg;

  localparam logic [3:0] OFF_DIR    = 4'd0;
  localparam logic [3:0] OFF_IN     = 4'd1;
  localparam logic [3:0] OFF_OUT    = 4'd2;
  localparam logic [3:0] OFF_SET    = 4'd3;
  localparam logic [3:0] OFF_CLR    = 4'd4;
  localparam logic [3:0] OFF_IEN    = 4'd5;
  localparam logic [3:0] OFF_IT0    = 4'd6;
  localparam logic [3:0] OFF_IT1    = 4'd7;
  localparam logic [3:0] OFF_IST    = 4'd8;
  localparam logic [3:0] OFF_IOF    = 4'd9;
  localparam logic [3:0] OFF_DEBEN  = 4'd10;
  localparam logic [3:0] OFF_DEBDIV = 4'd11;
  localparam logic [3:0] OFF_LAST   = 4'd11;

  typedef enum logic [1:0] {
    IT_LVL_HI = 2'b00,
    IT_LVL_LO = 2'b01,
    IT_RISE   = 2'b10,
    IT_FALL   = 2'b11
  } irq_type_e;

endpackage

// File: rtl/gpio_ext_if.sv
// GPIO_EXT APB4 slave bus bundle.
// Master drives request, slave drives response.
interface gpio_ext_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/gpio_ext_pin.sv
// GPIO_EXT per-pin path: synchroniser, debounce filter
// and raw interrupt event generation.
module gpio_ext_pin
  import gpio_ext_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      pin_i,
  input  logic      tick_i,
  input  logic      deben_i,
  input  irq_type_e itype_i,
  output logic      filt_o,
  output logic      evt_o
);

  logic [SYNC_STAGES-1:0] sync_q, svld_q;
  logic [2:0] hist_q, hist_d, hv_q, hv_d;
  logic deb_q, deb_d, dvld_q, dvld_d;
  logic prev_q, arm_q;
  logic s, svld, valid;

  assign s    = sync_q[SYNC_STAGES-1];
  assign svld = svld_q[SYNC_STAGES-1];

  always_comb begin
    hist_d = hist_q;
    hv_d   = hv_q;
    deb_d  = deb_q;
    dvld_d = dvld_q;
    if (tick_i && svld) begin
      hist_d = {hist_q[1:0], s};
      hv_d   = {hv_q[1:0], 1'b1};
      if ((&hv_d) && ((&hist_d) || !(|hist_d))) begin
        deb_d  = s;
        dvld_d = 1'b1;
      end
    end
  end

  assign filt_o = deben_i ? deb_q : s;
  assign valid  = deben_i ? dvld_q : svld;

  // prev_q is only trusted once the filter has produced a real value
  always_comb begin
    evt_o = 1'b0;
    unique case (itype_i)
      IT_LVL_HI: evt_o = filt_o;
      IT_LVL_LO: evt_o = !filt_o;
      IT_RISE:   evt_o = filt_o && !prev_q;
      IT_FALL:   evt_o = !filt_o && prev_q;
    endcase
    evt_o = evt_o && arm_q && valid;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      svld_q <= '0;
      hist_q <= '0;
      hv_q   <= '0;
      deb_q  <= 1'b0;
      dvld_q <= 1'b0;
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      svld_q <= {svld_q[SYNC_STAGES-2:0], 1'b1};
      hist_q <= hist_d;
      hv_q   <= hv_d;
      deb_q  <= deb_d;
      dvld_q <= dvld_d;
      prev_q <= filt_o;
      arm_q  <= arm_q | valid;
    end
  end

endmodule

// File: rtl/gpio_ext.sv
// GPIO_EXT top: APB4 register file, debounce prescaler,
// interrupt status and per-pin input conditioning.
module gpio_ext
  import gpio_ext_pkg::*;
#(
  parameter int GPIO_NUM    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                pclk_i,
  input  logic                presetn_i,
  input  logic [31:0]         paddr_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [31:0]         pwdata_i,
  input  logic [3:0]          pstrb_i,
  output logic                pready_o,
  output logic                pslverr_o,
  output logic [31:0]         prdata_o,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  output logic [GPIO_NUM-1:0] gpio_dir_o,
  output logic [GPIO_NUM-1:0] gpio_iof_o,
  output logic                irq_o
);

  typedef logic [GPIO_NUM-1:0]  vec_t;
  typedef logic [DIV_WIDTH-1:0] div_t;

  logic [3:0]  off;
  logic        bad, wr, tick, irq_q;
  logic [31:0] bm, wd, rd;
  vec_t dir_q, dir_d, out_q, out_d, ien_q, ien_d;
  vec_t it0_q, it0_d, it1_q, it1_d, ist_q, ist_d;
  vec_t iof_q, iof_d, deb_q, deb_d, filt, evt, vm, vw;
  div_t div_q, div_d, cnt_q, cnt_d;
  logic unused_addr;

  assign off = paddr_i[5:2];
  assign bad = off > OFF_LAST;
  assign wr  = psel_i & penable_i & pwrite_i & ~bad;
  assign bm  = {{8{pstrb_i[3]}}, {8{pstrb_i[2]}},
                {8{pstrb_i[1]}}, {8{pstrb_i[0]}}};
  assign wd  = pwdata_i & bm;
  assign vm  = vec_t'(bm);
  assign vw  = vec_t'(wd);
  assign unused_addr = ^{paddr_i[31:6], paddr_i[1:0]};

  assign tick  = cnt_q >= div_q;
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    ien_d = ien_q;
    it0_d = it0_q;
    it1_d = it1_q;
    ist_d = ist_q;
    iof_d = iof_q;
    deb_d = deb_q;
    div_d = div_q;
    if (wr) begin
      case (off)
        OFF_DIR:    dir_d = (dir_q & ~vm) | vw;
        OFF_OUT:    out_d = (out_q & ~vm) | vw;
        OFF_SET:    out_d = out_q | vw;
        OFF_CLR:    out_d = out_q & ~vw;
        OFF_IEN:    ien_d = (ien_q & ~vm) | vw;
        OFF_IT0:    it0_d = (it0_q & ~vm) | vw;
        OFF_IT1:    it1_d = (it1_q & ~vm) | vw;
        OFF_IST:    ist_d = ist_q & ~vw;
        OFF_IOF:    iof_d = (iof_q & ~vm) | vw;
        OFF_DEBEN:  deb_d = (deb_q & ~vm) | vw;
        OFF_DEBDIV: div_d = (div_q & ~div_t'(bm)) | div_t'(wd);
        default: ;
      endcase
    end
    // new events win over a same-cycle W1C
    ist_d = ist_d | (evt & ien_q);
  end

  always_comb begin
    rd = '0;
    case (off)
      OFF_DIR:    rd = 32'(dir_q);
      OFF_IN:     rd = 32'(filt);
      OFF_OUT:    rd = 32'(out_q);
      OFF_IEN:    rd = 32'(ien_q);
      OFF_IT0:    rd = 32'(it0_q);
      OFF_IT1:    rd = 32'(it1_q);
      OFF_IST:    rd = 32'(ist_q);
      OFF_IOF:    rd = 32'(iof_q);
      OFF_DEBEN:  rd = 32'(deb_q);
      OFF_DEBDIV: rd = 32'(div_q);
      default:    rd = '0;
    endcase
  end

  assign prdata_o   = psel_i ? rd : '0;
  assign pslverr_o  = psel_i & penable_i & bad;
  assign pready_o   = 1'b1;
  assign gpio_out_o = out_q;
  assign gpio_dir_o = dir_q;
  assign gpio_iof_o = iof_q;
  assign irq_o      = irq_q;

  for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
    gpio_ext_pin #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_pin (
      .clk_i   (pclk_i),
      .rst_ni  (presetn_i),
      .pin_i   (gpio_in_i[i]),
      .tick_i  (tick),
      .deben_i (deb_q[i]),
      .itype_i (irq_type_e'({it1_q[i], it0_q[i]})),
      .filt_o  (filt[i]),
      .evt_o   (evt[i])
    );
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      dir_q <= '0;
      out_q <= '0;
      ien_q <= '0;
      it0_q <= '0;
      it1_q <= '0;
      ist_q <= '0;
      iof_q <= '0;
      deb_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      out_q <= out_d;
      ien_q <= ien_d;
      it0_q <= it0_d;
      it1_q <= it1_d;
      ist_q <= ist_d;
      iof_q <= iof_d;
      deb_q <= deb_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      irq_q <= |ist_q;
    end
  end

endmodule

// File: tb/tb_gpio_ext.sv
// Directed bench for gpio_ext: register access, set/clear,
// edge/level interrupts, debounce and reset behaviour.
module tb_gpio_ext;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out, gpio_dir, gpio_iof;
  logic        irq;
  logic [31:0] rdat;
  logic        rerr;
  int checks   = 0;
  int failures = 0;

  gpio_ext_if apb ();

  always #5 clk = ~clk;

  gpio_ext dut (
    .pclk_i     (clk),
    .presetn_i  (rst_n),
    .paddr_i    (apb.paddr),
    .psel_i     (apb.psel),
    .penable_i  (apb.penable),
    .pwrite_i   (apb.pwrite),
    .pwdata_i   (apb.pwdata),
    .pstrb_i    (apb.pstrb),
    .pready_o   (apb.pready),
    .pslverr_o  (apb.pslverr),
    .prdata_o   (apb.prdata),
    .gpio_in_i  (gpio_in),
    .gpio_out_o (gpio_out),
    .gpio_dir_o (gpio_dir),
    .gpio_iof_o (gpio_iof),
    .irq_o      (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    @(negedge clk);
    apb.paddr = a; apb.pwdata = d; apb.pstrb = s;
    apb.pwrite = 1'b1; apb.psel = 1'b1; apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d,
                    output logic e);
    @(negedge clk);
    apb.paddr = a; apb.pwrite = 1'b0;
    apb.psel = 1'b1; apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    d = apb.prdata;
    e = apb.pslverr;
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    gpio_in = '0;
    apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", gpio_out, 32'h0);
    chk("rst_dir", gpio_dir, 32'h0);
    chk("rst_iof", gpio_iof, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("pready", 32'(apb.pready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // byte-lane strobes: only low two lanes land
    wr(32'h00, 32'hFFFF_00FF, 4'b0011);
    rd(32'h00, rdat, rerr);
    chk("dir_rd", rdat, 32'h0000_00FF);
    chk("dir_out", gpio_dir, 32'h0000_00FF);

    wr(32'h08, 32'h0F, 4'hF);
    wr(32'h0C, 32'h30, 4'hF);
    wr(32'h10, 32'h03, 4'hF);
    chk("setclr_out", gpio_out, 32'h3C);
    rd(32'h0C, rdat, rerr);
    chk("padset_rd", rdat, 32'h0);
    rd(32'h08, rdat, rerr);
    chk("padout_rd", rdat, 32'h3C);

    wr(32'h24, 32'hA5A5_A5A5, 4'hF);
    chk("iof_out", gpio_iof, 32'hA5A5_A5A5);

    wr(32'h30, 32'hFFFF_FFFF, 4'hF);
    rd(32'h30, rdat, rerr);
    chk("bad_err", 32'(rerr), 32'h1);
    chk("bad_rdata", rdat, 32'h0);
    chk("bad_nochg_out", gpio_out, 32'h3C);
    chk("bad_nochg_dir", gpio_dir, 32'h0000_00FF);
    rd(32'h00, rdat, rerr);
    chk("good_noerr", 32'(rerr), 32'h0);

    // rising-edge interrupt on pin 0
    wr(32'h1C, 32'h1, 4'hF);
    wr(32'h18, 32'h0, 4'hF);
    wr(32'h14, 32'h1, 4'hF);
    chk("irq_idle", 32'(irq), 32'h0);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_lag", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    chk("irq_rise", 32'(irq), 32'h1);
    rd(32'h20, rdat, rerr);
    chk("ist_rise", rdat, 32'h1);
    rd(32'h04, rdat, rerr);
    chk("padin_p0", rdat, 32'h1);
    wr(32'h20, 32'h1, 4'hF);
    @(posedge clk);
    #1;
    chk("irq_w1c", 32'(irq), 32'h0);
    rd(32'h20, rdat, rerr);
    chk("ist_w1c", rdat, 32'h0);

    // level-high: W1C while pin high does not stick
    wr(32'h1C, 32'h0, 4'hF);
    wr(32'h20, 32'h1, 4'hF);
    rd(32'h20, rdat, rerr);
    chk("ist_lvl", rdat, 32'h1);
    chk("irq_lvl", 32'(irq), 32'h1);
    wr(32'h14, 32'h0, 4'hF);
    rd(32'h20, rdat, rerr);
    chk("ist_keep", rdat, 32'h1);
    wr(32'h20, 32'h1, 4'hF);
    rd(32'h20, rdat, rerr);
    chk("ist_clr", rdat, 32'h0);
    chk("irq_clr", 32'(irq), 32'h0);

    // debounce on pin 1
    wr(32'h28, 32'h2, 4'hF);
    wr(32'h2C, 32'h3, 4'hF);
    rd(32'h2C, rdat, rerr);
    chk("debdiv_rd", rdat, 32'h3);
    @(negedge clk);
    gpio_in[1] = 1'b1;
    repeat (2) @(negedge clk);
    gpio_in[1] = 1'b0;
    repeat (20) @(posedge clk);
    rd(32'h04, rdat, rerr);
    chk("deb_pulse", rdat, 32'h1);
    @(negedge clk);
    gpio_in[1] = 1'b1;
    repeat (16) @(posedge clk);
    rd(32'h04, rdat, rerr);
    chk("deb_level", rdat, 32'h3);

    // reset mid-debounce with irq high
    wr(32'h14, 32'h1, 4'hF);
    @(negedge clk);
    gpio_in[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("irq_pre_rst", 32'(irq), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    gpio_in = 32'h3;
    #1;
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_out", gpio_out, 32'h0);
    chk("arst_dir", gpio_dir, 32'h0);
    chk("arst_iof", gpio_iof, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr(32'h1C, 32'h3, 4'hF);
    wr(32'h14, 32'h3, 4'hF);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_irq", 32'(irq), 32'h0);
    rd(32'h20, rdat, rerr);
    chk("post_rst_ist", rdat, 32'h0);
    rd(32'h04, rdat, rerr);
    chk("post_rst_padin", rdat, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_ext.md
GPIO_EXT -- requirements
Module: gpio_ext

Interface
REQ-001 SHALL have parameter GPIO_NUM, default 32, number of pins (legal range 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (legal range 2..4).
REQ-003 SHALL have parameter DIV_WIDTH, default 16, debounce prescaler width.
REQ-004 SHALL have port pclk_i, input, 1, the only clock.
REQ-005 SHALL have port presetn_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports paddr_i [31:0], psel_i, penable_i, pwrite_i, pwdata_i [31:0], pstrb_i [3:0] as APB4 inputs.
REQ-007 SHALL have ports pready_o (1), pslverr_o (1), prdata_o [31:0] as APB4 outputs.
REQ-008 SHALL have port gpio_in_i, input, GPIO_NUM, asynchronous pad inputs.
REQ-009 SHALL have ports gpio_out_o, gpio_dir_o, gpio_iof_o, each output, GPIO_NUM: pad data, direction (1 = output) and alternate-function select.
REQ-010 SHALL have port irq_o, output, 1, level interrupt.

Function
REQ-011 SHALL decode paddr_i[5:2]: 0 PADDIR RW, 1 PADIN RO, 2 PADOUT RW, 3 PADSET W1S, 4 PADCLR W1C-to-PADOUT, 5 INTEN RW, 6 INTTYPE0 RW, 7 INTTYPE1 RW, 8 INTSTATUS R/W1C, 9 IOFCFG RW, 10 DEBEN RW, 11 DEBDIV RW (DIV_WIDTH bits).
REQ-012 SHALL hold pready_o at 1 (zero wait states); pslverr_o SHALL be 1 in the access phase for offsets 12..15, and writes to those offsets SHALL have no effect.
REQ-013 SHALL commit writes only when psel_i, penable_i and pwrite_i are all 1, per byte lane as selected by pstrb_i.
REQ-014 SHALL return 0 on prdata_o for bits above GPIO_NUM and for PADSET/PADCLR reads.
REQ-015 SHALL pass gpio_in_i through a SYNC_STAGES flop chain per pin before any other use.
REQ-016 SHALL generate a one-cycle tick when a prescaler counter reaches DEBDIV, then reload the counter to 0; DEBDIV=0 SHALL produce a tick every cycle.
REQ-017 SHALL, for a pin with DEBEN=1, update its filtered value only on a tick on which the last 3 tick samples are equal; for a pin with DEBEN=0, the filtered value SHALL equal the synchroniser output.
REQ-018 SHALL read the filtered value through PADIN.
REQ-019 SHALL use {INTTYPE1,INTTYPE0} per pin: 00 level-high, 01 level-low, 10 rising edge, 11 falling edge; edges SHALL be detected on the filtered value against its value one cycle earlier.
REQ-020 SHALL set INTSTATUS[n] in the cycle after an event when INTEN[n]=1; a level event SHALL re-set the bit every cycle while the level persists.
REQ-021 SHALL give a same-cycle event set priority over a W1C clear.
REQ-022 SHALL give PADCLR priority over PADSET within one cycle; a direct PADOUT write SHALL take priority over both.
REQ-023 SHALL drive irq_o from a register equal to OR of INTSTATUS, one cycle after the status change.
REQ-024 SHALL not set status for pins with INTEN=0; clearing INTEN SHALL not clear existing status.
REQ-025 SHALL drive gpio_out_o, gpio_dir_o and gpio_iof_o directly from the PADOUT, PADDIR and IOFCFG registers.

Reset
REQ-026 SHALL asynchronously reset all registers, synchroniser and filter state, prescaler, and irq_o to 0 on presetn_i low.
REQ-027 SHALL NOT detect a spurious edge after reset release: the first filtered update SHALL also load the previous-value register.

Structure
REQ-028 SHALL place the register offset constants and the interrupt-type enum in a shared package gpio_ext_pkg.
REQ-029 SHALL implement the per-pin synchroniser, debounce and edge-detect logic in one sub-module, gpio_ext_pin, instantiated GPIO_NUM times.

Verification
REQ-030 SHALL cover: write 0x0F to PADOUT, 0x30 to PADSET, 0x03 to PADCLR -> gpio_out_o reads 0x3C.
REQ-031 SHALL cover: INTEN[0]=1, type 10, gpio_in_i[0] driven 0->1 with DEBEN=0 -> INTSTATUS=0x1 within SYNC_STAGES+1 cycles and irq_o one cycle later; W1C 0x1 -> irq_o low.
REQ-032 SHALL cover: DEBEN[1]=1, DEBDIV=3, a 2-cycle pulse on pin 1 -> PADIN[1] unchanged; a level held 16 cycles -> PADIN[1]=1.
REQ-033 SHALL cover: level-high interrupt, W1C issued while the pin is still high -> INTSTATUS bit remains 1.
REQ-034 SHALL cover: access to offset 0x30 -> pslverr_o=1, prdata_o=0, no register change.
REQ-035 SHALL cover: presetn_i asserted mid-debounce with irq_o high -> all outputs 0 immediately, and no interrupt after release with inputs held high under edge type.
